// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared encodings for the capture sequencer
package capture_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_WARMUP  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [3:0] WE_ALL = 4'hF;

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - command, mic strobe and BRAM-side signal bundle
interface capture_sequencer_if;

   logic        cmd_start;
   logic        cmd_stop;
   logic        cfg_continuous;
   logic [1:0]  buf_ack;
   logic        m_clk_rising;
   logic        sample_valid;
   logic        mic_rst;
   logic [31:0] bram_addr;
   logic [3:0]  bram_we;
   logic [1:0]  half_ready;
   logic        irq;
   logic        overrun;
   logic        busy;
   logic [1:0]  state;

   modport master (
      output cmd_start, cmd_stop, cfg_continuous, buf_ack, m_clk_rising, sample_valid,
      input  mic_rst, bram_addr, bram_we, half_ready, irq, overrun, busy, state
   );

   modport slave (
      input  cmd_start, cmd_stop, cfg_continuous, buf_ack, m_clk_rising, sample_valid,
      output mic_rst, bram_addr, bram_we, half_ready, irq, overrun, busy, state
   );

endinterface

// File: rtl/capture_addr_gen.sv
// rtl/capture_addr_gen.sv - BRAM word index, ping-pong half flags and overrun detection
module capture_addr_gen
   import capture_pkg::*;
#(
   parameter int COUNT_WIDTH = 14
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic        wr_en,
   input  logic [1:0]  buf_ack,
   output logic        at_last,
   output logic [31:0] bram_addr,
   output logic [3:0]  bram_we,
   output logic [1:0]  half_ready,
   output logic        irq,
   output logic        overrun
);

   localparam logic [COUNT_WIDTH-1:0] HALF_LAST = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
   localparam logic [COUNT_WIDTH-1:0] FULL_LAST = '1;

   logic [COUNT_WIDTH-1:0] idx;
   logic [1:0]             half_set;
   logic                   half_sel;
   logic                   half_entry;

   assign at_last    = (idx == FULL_LAST);
   assign half_sel   = idx[COUNT_WIDTH-1];
   assign half_entry = (idx[COUNT_WIDTH-2:0] == '0);
   assign half_set   = {wr_en && (idx == FULL_LAST), wr_en && (idx == HALF_LAST)};

   // Register the write strobe/address and maintain flags; a set beats an ack in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx        <= '0;
         bram_addr  <= '0;
         bram_we    <= 4'h0;
         half_ready <= 2'b00;
         irq        <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         bram_we <= wr_en ? WE_ALL : 4'h0;
         irq     <= |half_set;
         if (wr_en) begin
            bram_addr <= 32'(idx) << 2;
            idx       <= idx + 1'b1;
         end
         if (clear) begin
            idx        <= '0;
            half_ready <= 2'b00;
            overrun    <= 1'b0;
         end else begin
            half_ready <= (half_ready & ~buf_ack) | half_set;
            if (wr_en && half_entry && half_ready[half_sel])
               overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - PDM capture session FSM with mic warm-up and BRAM write sequencing
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int COUNT_WIDTH  = 14,
   parameter int WARMUP_EDGES = 24000
) (
   input  logic clk,
   input  logic rstn,
   capture_sequencer_if.slave bus
);

   localparam int WARM_W = $clog2(WARMUP_EDGES + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_EDGES - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WARM_W-1:0] warm_cnt;
   logic              cont_q;
   logic              start_go;
   logic              wr_en;
   logic              at_last;
   logic              mic_rst_q;
   logic              busy_q;

   // Stop always wins over a coincident start.
   assign start_go = bus.cmd_start && !bus.cmd_stop;

   // Next state and write enable; commands pre-empt any pending write.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      if (bus.cmd_stop) begin
         state_d = ST_IDLE;
      end else if (bus.cmd_start) begin
         state_d = ST_WARMUP;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (bus.m_clk_rising && (warm_cnt == WARM_LAST))
                  state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (bus.sample_valid) begin
                  wr_en = 1'b1;
                  if (at_last && !cont_q)
                     state_d = ST_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // State register; mic reset and busy are derived from the next state so they move with it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         mic_rst_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mic_rst_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
         busy_q    <= (state_d == ST_WARMUP) || (state_d == ST_CAPTURE);
      end
   end

   // Warm-up edge counter, restarted by every accepted start.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         warm_cnt <= '0;
      end else if (start_go) begin
         warm_cnt <= '0;
      end else if ((state_q == ST_WARMUP) && bus.m_clk_rising) begin
         warm_cnt <= warm_cnt + 1'b1;
      end
   end

   // Session mode is captured only when a session starts.
   always_ff @(posedge clk) begin
      if (!rstn)
         cont_q <= 1'b0;
      else if (start_go)
         cont_q <= bus.cfg_continuous;
   end

   capture_addr_gen #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_addr_gen (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (start_go),
      .wr_en      (wr_en),
      .buf_ack    (bus.buf_ack),
      .at_last    (at_last),
      .bram_addr  (bus.bram_addr),
      .bram_we    (bus.bram_we),
      .half_ready (bus.half_ready),
      .irq        (bus.irq),
      .overrun    (bus.overrun)
   );

   assign bus.state   = state_q;
   assign bus.mic_rst = mic_rst_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed checks for capture_sequencer
module tb_capture_sequencer;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   capture_sequencer_if bus();

   capture_sequencer #(
      .COUNT_WIDTH  (4),
      .WARMUP_EDGES (3)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " state"},      32'(bus.state), 0);
      check({tag, " mic_rst"},    32'(bus.mic_rst), 1);
      check({tag, " bram_addr"},  bus.bram_addr, 0);
      check({tag, " bram_we"},    32'(bus.bram_we), 0);
      check({tag, " half_ready"}, 32'(bus.half_ready), 0);
      check({tag, " irq"},        32'(bus.irq), 0);
      check({tag, " overrun"},    32'(bus.overrun), 0);
      check({tag, " busy"},       32'(bus.busy), 0);
   endtask

   task automatic start(input logic cont);
      bus.cmd_start      = 1'b1;
      bus.cfg_continuous = cont;
      step();
      bus.cmd_start = 1'b0;
      check("start state", 32'(bus.state), 1);
      check("start mic_rst", 32'(bus.mic_rst), 0);
      check("start busy", 32'(bus.busy), 1);
   endtask

   task automatic warm();
      for (int k = 0; k < 3; k++) begin
         bus.m_clk_rising = 1'b1;
         step();
         bus.m_clk_rising = 1'b0;
         check("warm state", 32'(bus.state), (k == 2) ? 2 : 1);
      end
   endtask

   task automatic sample(input int w, input logic [1:0] ack);
      bus.sample_valid = 1'b1;
      bus.buf_ack      = ack;
      step();
      bus.sample_valid = 1'b0;
      bus.buf_ack      = 2'b00;
      check("wr addr", bus.bram_addr, (w % 16) * 4);
      check("wr we", 32'(bus.bram_we), 32'hF);
      check("wr irq", 32'(bus.irq), ((w % 8) == 7) ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.cmd_start      = 1'b0;
      bus.cmd_stop       = 1'b0;
      bus.cfg_continuous = 1'b0;
      bus.buf_ack        = 2'b00;
      bus.m_clk_rising   = 1'b0;
      bus.sample_valid   = 1'b0;

      step();
      step();
      check_reset("por");
      rstn = 1'b1;
      step();
      check("idle hold", 32'(bus.state), 0);

      // single-shot session; sample before warm-up done must not write
      start(1'b0);
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      check("warmup no write", 32'(bus.bram_we), 0);
      warm();
      for (int w = 0; w < 16; w++) begin
         sample(w, 2'b00);
         if (w == 7) check("half0 set", 32'(bus.half_ready), 1);
      end
      check("ss half_ready", 32'(bus.half_ready), 3);
      check("ss state", 32'(bus.state), 3);
      check("ss mic_rst", 32'(bus.mic_rst), 1);
      check("ss busy", 32'(bus.busy), 0);
      step();
      check("ss idle we", 32'(bus.bram_we), 0);
      check("ss irq pulse", 32'(bus.irq), 0);
      check("ss addr hold", bus.bram_addr, 32'h3C);
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      check("done no write", 32'(bus.bram_we), 0);
      bus.buf_ack = 2'b10;
      step();
      bus.buf_ack = 2'b00;
      check("done ack", 32'(bus.half_ready), 1);
      check("done stays", 32'(bus.state), 3);

      // continuous: ack half 0 only
      start(1'b1);
      check("cont clr hr", 32'(bus.half_ready), 0);
      warm();
      for (int w = 0; w < 8; w++) sample(w, 2'b00);
      bus.buf_ack = 2'b01;
      step();
      bus.buf_ack = 2'b00;
      check("cont ack0", 32'(bus.half_ready), 0);
      for (int w = 8; w < 16; w++) sample(w, 2'b00);
      check("cont hr1", 32'(bus.half_ready), 2);
      check("cont state", 32'(bus.state), 2);
      sample(16, 2'b00);
      check("no ovr half0", 32'(bus.overrun), 0);
      for (int w = 17; w < 24; w++) sample(w, 2'b00);
      check("cont hr both", 32'(bus.half_ready), 3);
      sample(24, 2'b00);
      check("ovr half1", 32'(bus.overrun), 1);

      // ack coincident with half-0 completion: set wins
      start(1'b1);
      check("restart ovr clr", 32'(bus.overrun), 0);
      warm();
      for (int w = 0; w < 7; w++) sample(w, 2'b00);
      sample(7, 2'b01);
      check("set beats ack", 32'(bus.half_ready), 1);
      step();
      check("set held", 32'(bus.half_ready), 1);

      // stop with a pending sample, then start+stop together, then restart
      for (int w = 8; w < 13; w++) sample(w, 2'b00);
      bus.cmd_stop     = 1'b1;
      bus.sample_valid = 1'b1;
      step();
      bus.cmd_stop     = 1'b0;
      bus.sample_valid = 1'b0;
      check("stop state", 32'(bus.state), 0);
      check("stop we", 32'(bus.bram_we), 0);
      check("stop mic_rst", 32'(bus.mic_rst), 1);
      check("stop busy", 32'(bus.busy), 0);
      check("stop addr", bus.bram_addr, 32'h30);
      check("stop hr held", 32'(bus.half_ready), 1);
      bus.cmd_start = 1'b1;
      bus.cmd_stop  = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      bus.cmd_stop  = 1'b0;
      check("stop wins", 32'(bus.state), 0);
      check("stop wins hr", 32'(bus.half_ready), 1);
      start(1'b1);
      check("restart hr", 32'(bus.half_ready), 0);
      warm();
      sample(0, 2'b00);

      // reset in the middle of capture
      sample(1, 2'b00);
      sample(2, 2'b00);
      rstn             = 1'b0;
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      check_reset("mid rst");
      rstn = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
